// File: rtl/uart_time_reporter_pkg.sv
// uart_time_reporter_pkg: ASCII constants, message lengths and FSM states shared by the time reporter.
package uart_time_reporter_pkg;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam int MSG_LEN_CRLF   = 10;
    localparam int MSG_LEN_NOCRLF = 8;
    typedef enum logic [2:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE, NEXT} state_t;
endpackage

// File: rtl/uart_time_reporter_if.sv
// uart_time_reporter_if: request, BCD time, transmitter handshake and status bundle.
interface uart_time_reporter_if;
    logic       send_req;
    logic [7:0] hours_bcd;
    logic [7:0] minutes_bcd;
    logic [7:0] seconds_bcd;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       ack_err;
    modport master (
        output send_req, hours_bcd, minutes_bcd, seconds_bcd, tx_busy,
        input  tx_start, tx_data, busy, done, overrun, ack_err
    );
    modport slave (
        input  send_req, hours_bcd, minutes_bcd, seconds_bcd, tx_busy,
        output tx_start, tx_data, busy, done, overrun, ack_err
    );
endinterface

// File: rtl/uart_time_reporter_bcd_to_ascii.sv
// bcd_to_ascii: one BCD nibble to its ASCII digit, '?' for non-decimal nibbles.
module bcd_to_ascii
    import uart_time_reporter_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] char_o
);
    always_comb char_o = (nib_i > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {4'd0, nib_i};
endmodule

// File: rtl/uart_time_reporter.sv
// uart_time_reporter: snapshots BCD time on request and streams "HH:MM:SS"[CR LF] to a UART transmitter.
module uart_time_reporter
    import uart_time_reporter_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR    = ASCII_COLON,
    parameter bit         SEND_CRLF   = 1'b1,
    parameter int         ACK_TIMEOUT = 64
)(
    input  logic                clk,
    input  logic                rst_n,
    uart_time_reporter_if.slave bus
);
    localparam int         TW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0] LAST = SEND_CRLF ? 4'(MSG_LEN_CRLF - 1) : 4'(MSG_LEN_NOCRLF - 1);

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] to_q, to_d;
    logic [23:0]   snap_q, snap_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          overrun_q, overrun_d, ack_err_q, ack_err_d;
    logic [3:0]    nib;
    logic [7:0]    digit, ch;
    logic          accept, launch, timeout, finish;

    assign nib = idx_q == 4'd0 ? snap_q[23:20] :
                 idx_q == 4'd1 ? snap_q[19:16] :
                 idx_q == 4'd3 ? snap_q[15:12] :
                 idx_q == 4'd4 ? snap_q[11:8]  :
                 idx_q == 4'd6 ? snap_q[7:4]   : snap_q[3:0];

    bcd_to_ascii u_conv (.nib_i(nib), .char_o(digit));

    assign ch = (idx_q == 4'd2 || idx_q == 4'd5) ? SEP_CHAR :
                idx_q == 4'd8 ? ASCII_CR :
                idx_q == 4'd9 ? ASCII_LF : digit;

    // The done cycle already shows busy low, yet a request there still counts as overlapping.
    assign accept  = state_q == IDLE && bus.send_req && !done_q;
    assign launch  = state_q == STROBE && !bus.tx_busy;
    assign timeout = state_q == WAIT_ACK && !bus.tx_busy && to_q == TW'(ACK_TIMEOUT - 1);
    assign finish  = state_q == NEXT && idx_q == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            to_q       <= '0;
            snap_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            to_q       <= to_d;
            snap_q     <= snap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            ack_err_q  <= ack_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        to_d    = to_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = STROBE;
                idx_d   = '0;
                snap_d  = {bus.hours_bcd, bus.minutes_bcd, bus.seconds_bcd};
            end
            STROBE: if (launch) begin
                state_d = WAIT_ACK;
                to_d    = '0;
            end
            WAIT_ACK: begin
                state_d = bus.tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_ACK;
                to_d    = to_q + 1'b1;
            end
            WAIT_DONE: if (!bus.tx_busy) state_d = NEXT;
            NEXT: begin
                state_d = finish ? IDLE : STROBE;
                idx_d   = finish ? idx_q : idx_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_d = launch;
        tx_data_d  = launch ? ch : tx_data_q;
        busy_d     = accept ? 1'b1 : (timeout || finish) ? 1'b0 : busy_q;
        done_d     = finish;
        overrun_d  = accept ? 1'b0 : bus.send_req ? 1'b1 : overrun_q;
        ack_err_d  = accept ? 1'b0 : timeout ? 1'b1 : ack_err_q;
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;
    assign bus.ack_err  = ack_err_q;
endmodule

// File: tb/tb_uart_time_reporter.sv
// tb_uart_time_reporter: directed checks of the time reporter against a 20-cycle transmitter model.
module tb_uart_time_reporter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_time_reporter_if ifa ();
    uart_time_reporter_if ifb ();

    uart_time_reporter #(.SEND_CRLF(1'b1), .ACK_TIMEOUT(64)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    uart_time_reporter #(.SEND_CRLF(1'b0), .ACK_TIMEOUT(64)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    logic en_a = 1'b1;
    logic ext_busy = 1'b0;
    int cnt_a, cnt_b;
    int dca = 0;
    int dcb = 0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];

    // Transmitter model: busy from the cycle after tx_start for 20 cycles
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_a <= 0;
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
        else if (en_a && ifa.tx_start) cnt_a <= 20;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_b <= 0;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
        else if (ifb.tx_start) cnt_b <= 20;
    assign ifa.tx_busy = (cnt_a != 0) || ext_busy;
    assign ifb.tx_busy = (cnt_b != 0);

    always @(posedge clk) begin
        if (ifa.tx_start) qa.push_back(ifa.tx_data);
        if (ifb.tx_start) qb.push_back(ifb.tx_data);
        if (ifa.done) dca <= dca + 1;
        if (ifb.done) dcb <= dcb + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pick(input bit sel, input int k);
        if (sel) return (k < qb.size()) ? qb[k] : 8'hxx;
        return (k < qa.size()) ? qa[k] : 8'hxx;
    endfunction

    task automatic chk_msg(input string tag, input bit sel, input int base, input logic [7:0] e [10], input int n);
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), pick(sel, base + i), e[i]);
    endtask

    task automatic send(input bit sel, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        if (sel) begin
            ifb.hours_bcd = h; ifb.minutes_bcd = m; ifb.seconds_bcd = s; ifb.send_req = 1'b1;
        end else begin
            ifa.hours_bcd = h; ifa.minutes_bcd = m; ifa.seconds_bcd = s; ifa.send_req = 1'b1;
        end
        @(negedge clk);
        ifa.send_req = 1'b0;
        ifb.send_req = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output bit ok, output logic pb);
        ok = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            pb = sel ? ifb.busy : ifa.busy;
            @(negedge clk);
            if (sel ? ifb.done : ifa.done) ok = 1'b1;
        end
    endtask

    task automatic wait_bytes(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (qa.size() - base >= n) ok = 1'b1;
        end
    endtask

    logic [7:0] m_1234 [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    logic [7:0] m_0905 [10] = '{8'h30, 8'h39, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h30, 8'h30, 8'h00, 8'h00};
    logic [7:0] m_a7   [10] = '{8'h3F, 8'h37, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};

    initial begin
        bit ok;
        logic pb;
        int base, d0, n;
        ifa.send_req = 1'b0; ifa.hours_bcd = 8'h00; ifa.minutes_bcd = 8'h00; ifa.seconds_bcd = 8'h00;
        ifb.send_req = 1'b0; ifb.hours_bcd = 8'h00; ifb.minutes_bcd = 8'h00; ifb.seconds_bcd = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", ifa.tx_start, 0);
        chk("rst_tx_data", ifa.tx_data, 8'h00);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_overrun", ifa.overrun, 0);
        chk("rst_ack_err", ifa.ack_err, 0);
        rst_n = 1'b1;

        // 12:34:56 with CR LF; inputs changed right after the request
        base = qa.size(); d0 = dca;
        send(0, 8'h12, 8'h34, 8'h56);
        ifa.hours_bcd = 8'h23; ifa.minutes_bcd = 8'h59; ifa.seconds_bcd = 8'h59;
        chk("t1_busy_after_req", ifa.busy, 1);
        wait_done(0, ok, pb);
        chk("t1_done_seen", ok, 1);
        chk("t1_busy_at_done", ifa.busy, 0);
        chk("t1_busy_before_done", pb, 1);
        chk("t1_nbytes", qa.size() - base, 10);
        chk_msg("t1", 0, base, m_1234, 10);
        repeat (5) @(negedge clk);
        chk("t1_done_count", dca - d0, 1);

        // Request during the third character is dropped and flagged
        base = qa.size();
        send(0, 8'h12, 8'h34, 8'h56);
        wait_bytes(base, 3, ok);
        chk("ov_reach3", ok, 1);
        ifa.send_req = 1'b1; ifa.hours_bcd = 8'h23;
        @(negedge clk);
        ifa.send_req = 1'b0;
        chk("ov_set", ifa.overrun, 1);
        wait_done(0, ok, pb);
        chk("ov_done_seen", ok, 1);
        chk("ov_sticky", ifa.overrun, 1);
        chk("ov_nbytes", qa.size() - base, 10);
        chk_msg("ov", 0, base, m_1234, 10);

        // Invalid hours tens digit; the accepted request clears overrun
        base = qa.size();
        send(0, 8'hA7, 8'h00, 8'h00);
        chk("ov_cleared", ifa.overrun, 0);
        wait_done(0, ok, pb);
        chk("inv_done_seen", ok, 1);
        chk_msg("inv", 0, base, m_a7, 2);

        // Transmitter owned elsewhere: first strobe held until tx_busy drops
        ext_busy = 1'b1;
        base = qa.size();
        send(0, 8'h00, 8'h00, 8'h00);
        repeat (30) @(negedge clk);
        chk("hold_no_start", qa.size() - base, 0);
        chk("hold_busy", ifa.busy, 1);
        chk("hold_no_ackerr", ifa.ack_err, 0);
        ext_busy = 1'b0;
        wait_done(0, ok, pb);
        chk("hold_done_seen", ok, 1);
        chk("hold_nbytes", qa.size() - base, 10);
        chk("hold_byte0", pick(0, base), 8'h30);

        // No CR LF variant
        base = qb.size(); d0 = dcb;
        send(1, 8'h09, 8'h05, 8'h00);
        wait_done(1, ok, pb);
        chk("b_done_seen", ok, 1);
        chk("b_busy_at_done", ifb.busy, 0);
        repeat (40) @(negedge clk);
        chk("b_nbytes", qb.size() - base, 8);
        chk_msg("b", 1, base, m_0905, 8);
        chk("b_done_count", dcb - d0, 1);

        // Transmitter never acknowledges
        en_a = 1'b0;
        base = qa.size(); d0 = dca;
        send(0, 8'h12, 8'h34, 8'h56);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) if (ifa.tx_start) ok = 1'b1; else @(negedge clk);
        chk("to_start_seen", ok, 1);
        n = 0;
        while (!ifa.ack_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 64);
        chk("to_busy", ifa.busy, 0);
        repeat (20) @(negedge clk);
        chk("to_one_start", qa.size() - base, 1);
        chk("to_no_done", dca - d0, 0);
        chk("to_sticky", ifa.ack_err, 1);
        en_a = 1'b1;

        // Reset during WAIT_DONE of the fifth byte
        base = qa.size();
        send(0, 8'h12, 8'h34, 8'h56);
        chk("rr_ackerr_cleared", ifa.ack_err, 0);
        wait_bytes(base, 5, ok);
        chk("rr_reach5", ok, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_tx_start", ifa.tx_start, 0);
        chk("rr_tx_data", ifa.tx_data, 8'h00);
        chk("rr_busy", ifa.busy, 0);
        chk("rr_done", ifa.done, 0);
        chk("rr_overrun", ifa.overrun, 0);
        chk("rr_ack_err", ifa.ack_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("rr_no_more_start", qa.size() - base, 5);
        chk("rr_idle", ifa.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
